// File: rtl/mips_file_multi_pkg.sv
// Shared definitions for the multi-port byte-lane register file.
package mips_file_multi_pkg;

  // Width of one byte-write lane.
  localparam int unsigned LANE_W = 8;

  // Sequencer states: CLEAR zeroes the array after reset, RUN is normal operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/mips_file_lane.sv
// One 8-bit x 2^AW storage bank with a single write port and an
// asynchronous read port. There is no reset, because SRAM arrays
// cannot be reset in place; the top level clears the bank instead.
// Ports:
//   clock   - write clock
//   we      - write enable
//   waddr   - write address
//   wdata   - write byte
//   raddr   - read address
//   rdata_c - combinational read byte
module mips_file_lane
  import mips_file_multi_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [LANE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [LANE_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [LANE_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read port.
  assign rdata_c = mem[raddr];

endmodule

// File: rtl/mips_file_multi.sv
// Parametrised byte-lane-writable register file with READS asynchronous
// read ports. Register 0 reads as zero. After reset, a sequencer zeroes
// entries 1..2^AW-1 and then raises ready. Optional same-cycle
// write-to-read bypass works per lane.
// Ports:
//   clock - clock; all state changes on the rising edge
//   reset - synchronous, active-high
//   ready - high once the post-reset clear has finished
//   rd    - write address
//   we    - per-byte write enables
//   D     - write data
//   rs    - packed read addresses; port k uses rs[k*AW +: AW]
//   S     - packed read data; port k drives S[k*WIDTH +: WIDTH]
module mips_file_multi
  import mips_file_multi_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LANES  = WIDTH / 8,
  parameter int unsigned AW     = 5,
  parameter int unsigned READS  = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   ready,
  input  logic [AW-1:0]          rd,
  input  logic [LANES-1:0]       we,
  input  logic [WIDTH-1:0]       D,
  input  logic [READS*AW-1:0]    rs,
  output logic [READS*WIDTH-1:0] S
);

  state_t          state;
  logic [AW-1:0]   cnt;
  logic            clearing;

  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [LANES-1:0] wr_en;

  assign clearing = (state == ST_CLEAR);

  // Clear sequencer. cnt stops on its last value instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_CLEAR;
      cnt   <= AW'(1);
      ready <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (cnt == '1) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // Write mux. Reset blocks writes. CLEAR forces zero data into entry cnt.
  // Writes to register 0 are dropped.
  always_comb begin
    wr_addr = rd;
    wr_data = D;
    wr_en   = '0;
    if (!reset) begin
      if (clearing) begin
        wr_addr = cnt;
        wr_data = '0;
        wr_en   = '1;
      end else if (rd != '0) begin
        wr_en = we;
      end
    end
  end

  // Each read port has its own copy of every lane bank, and every copy
  // receives the same write.
  for (genvar k = 0; k < READS; k++) begin : g_port
    logic [AW-1:0] addr;
    assign addr = rs[k*AW +: AW];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [LANE_W-1:0] stored;
      logic              hit;

      mips_file_lane #(.AW(AW)) u_bank (
        .clock   (clock),
        .we      (wr_en[i]),
        .waddr   (wr_addr),
        .wdata   (wr_data[i*LANE_W +: LANE_W]),
        .raddr   (addr),
        .rdata_c (stored)
      );

      // Forward the incoming byte when this lane is written to the same entry in this cycle.
      assign hit = (BYPASS != 0) && !clearing && (addr == rd) && (rd != '0) && we[i];

      assign S[k*WIDTH + i*LANE_W +: LANE_W] =
        (clearing || addr == '0) ? '0 :
        hit                      ? D[i*LANE_W +: LANE_W] :
                                   stored;
    end
  end

endmodule

// File: tb/tb_mips_file_multi.sv
module tb_mips_file_multi;

  logic        clock;
  logic        reset;
  logic [4:0]  rd;
  logic [3:0]  we;
  logic [31:0] D;
  logic [9:0]  rs;
  logic [63:0] s_byp, s_nob;
  logic        rdy_byp, rdy_nob;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];
  bit          running = 0;

  typedef struct packed {
    logic        dut;   // 0 = bypass build, 1 = no-bypass build
    logic        port;
    logic [31:0] exp;
  } sb_t;

  sb_t   item_q [$];
  string tag_q  [$];

  mips_file_multi #(.WIDTH(32), .AW(5), .READS(2), .BYPASS(1)) u_byp (
    .clock (clock), .reset (reset), .ready (rdy_byp),
    .rd (rd), .we (we), .D (D), .rs (rs), .S (s_byp)
  );

  mips_file_multi #(.WIDTH(32), .AW(5), .READS(2), .BYPASS(0)) u_nob (
    .clock (clock), .reset (reset), .ready (rdy_nob),
    .rd (rd), .we (we), .D (D), .rs (rs), .S (s_nob)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference read for the current inputs, from the bench's own array model.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    logic [31:0] r;
    if (!running || a == 5'd0) return 32'h0;
    r = model[a];
    if (byp && a == rd && rd != 5'd0)
      for (int i = 0; i < 4; i++)
        if (we[i]) r[8*i +: 8] = D[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] get_s(input logic dut, input logic port);
    logic [63:0] v;
    v = dut ? s_nob : s_byp;
    return port ? v[63:32] : v[31:0];
  endfunction

  // Push expected reads for both builds and both ports.
  task automatic sb_push(input string tag);
    sb_t it;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        it.dut  = 1'(d);
        it.port = 1'(p);
        it.exp  = exp_read(rs[p*5 +: 5], d == 0);
        item_q.push_back(it);
        tag_q.push_back($sformatf("%s_d%0d_p%0d", tag, d, p));
      end
  endtask

  // Let the combinational read path settle, then compare everything queued.
  task automatic drain();
    sb_t   it;
    string t;
    #1;
    while (item_q.size() > 0) begin
      it = item_q.pop_front();
      t  = tag_q.pop_front();
      check(t, get_s(it.dut, it.port), it.exp);
    end
  endtask

  // One clock edge. The model takes the write that the edge should commit.
  task automatic step();
    logic [4:0]  a;
    logic [3:0]  w;
    logic [31:0] d;
    a = rd; w = we; d = D;
    @(posedge clock);
    if (reset) begin
      running = 0;
      for (int e = 0; e < 32; e++) model[e] = 32'h0;
    end else if (running && a != 5'd0) begin
      for (int i = 0; i < 4; i++)
        if (w[i]) model[a][8*i +: 8] = d[8*i +: 8];
    end
    #1;
  endtask

  // Walk the 31 clear edges after reset release.
  task automatic do_clear(input bit inject);
    for (int n = 1; n <= 31; n++) begin
      if (inject && n == 5) begin
        rd = 5'd2; we = 4'hF; D = 32'hDEADBEEF; rs = {5'd2, 5'd2};
      end else begin
        rd = 5'd0; we = 4'h0;
        rs = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
      end
      sb_push("clear_rd");
      drain();
      step();
      check("ready_byp", 32'(rdy_byp), 32'(n == 31));
      check("ready_nob", 32'(rdy_nob), 32'(n == 31));
    end
    we = 4'h0; rd = 5'd0;
    running = 1;
  endtask

  task automatic read_all(input string tag);
    we = 4'h0;
    for (int e = 0; e < 32; e += 2) begin
      rs = {5'(e + 1), 5'(e)};
      sb_push(tag);
      drain();
    end
  endtask

  initial begin
    reset = 1'b1; rd = 5'd0; we = 4'h0; D = 32'h0; rs = {5'd3, 5'd1};
    step();
    step();
    check("reset_ready_byp", 32'(rdy_byp), 32'h0);
    check("reset_ready_nob", 32'(rdy_nob), 32'h0);
    sb_push("reset_rd");
    drain();
    reset = 1'b0;
    do_clear(1'b1);

    // An entry written during CLEAR stays zero.
    rs = {5'd2, 5'd2};
    sb_push("clear_wr_r2");
    drain();

    // Byte lanes.
    rd = 5'd5; we = 4'hF; D = 32'h11223344; step();
    we = 4'b0101; D = 32'hAABBCCDD; step();
    we = 4'h0; rs = {5'd5, 5'd5};
    sb_push("lanes_r5");
    drain();
    check("lanes_r5_abs", get_s(1'b0, 1'b0), 32'h11BB33DD);

    // Register 0 ignores writes and is never bypassed.
    rd = 5'd0; we = 4'hF; D = 32'hFFFFFFFF; rs = {5'd0, 5'd0};
    sb_push("r0_same");
    drain();
    step();
    we = 4'h0;
    sb_push("r0_after");
    drain();

    // Bypass on the high lane only.
    rd = 5'd7; we = 4'hF; D = 32'h01020304; step();
    we = 4'b1000; D = 32'hEE000000; rs = {5'd7, 5'd7};
    sb_push("bypass");
    drain();
    check("bypass_abs_on",  get_s(1'b0, 1'b0), 32'hEE020304);
    check("bypass_abs_off", get_s(1'b1, 1'b0), 32'h01020304);
    step();
    we = 4'h0;
    sb_push("bypass_after");
    drain();

    // Random traffic, with reads that often alias the write address.
    for (int n = 0; n < 60; n++) begin
      rd = 5'($urandom_range(0, 31));
      we = 4'($urandom_range(0, 15));
      D  = $urandom;
      rs[4:0] = ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 31));
      rs[9:5] = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      sb_push("rand");
      drain();
      step();
    end
    read_all("rand_all");

    // Reset from RUN, then again after 10 clear edges, with a write on the reset edge.
    reset = 1'b1; we = 4'h0; step();
    reset = 1'b0;
    for (int n = 0; n < 10; n++) step();
    check("midclear_ready", 32'(rdy_byp), 32'h0);
    reset = 1'b1; rd = 5'd4; we = 4'hF; D = 32'h12345678; step();
    reset = 1'b0; we = 4'h0; rd = 5'd0;
    check("reset2_ready", 32'(rdy_nob), 32'h0);
    do_clear(1'b0);
    read_all("post_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
